// File: rtl/automaton_pkg.sv
// Shared types and helpers for the cellular-automaton grid engine.
package automaton_pkg;

   localparam int RULE_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_N,
      LOAD_C,
      LOAD_S,
      WRITE,
      SHIFT,
      DONE
   } state_t;

   // Neighbourhood index into the rule table, N is the MSB.
   function automatic logic [4:0] rule_idx(input logic n, input logic w, input logic c,
                                           input logic e, input logic s);
      return {n, w, c, e, s};
   endfunction

endpackage

// File: rtl/automaton_line_buf.sv
// One world row held on chip: per-column capture from the world bus, or parallel load.
module automaton_line_buf #(
   parameter int COLS  = 64,
   parameter int COL_W = $clog2(COLS)
) (
   input  logic             clk,
   input  logic             bit_we,
   input  logic [COL_W-1:0] bit_idx,
   input  logic             bit_val,
   input  logic             par_we,
   input  logic [COLS-1:0]  par_val,
   output logic [COLS-1:0]  q
);

   // No reset: contents are always loaded before they are used.
   always_ff @(posedge clk) begin
      if (par_we)
         q <= par_val;
      else if (bit_we)
         q[bit_idx] <= bit_val;
   end

endmodule

// File: rtl/automaton_grid_engine.sv
// Next-generation engine for a 5-neighbour cellular automaton over an external ROWS x COLS world.
// Define AUTOMATON_TORUS_EN for wrap-around edges (adds the LOAD_N pass and the tbuf copy of row 0).
//
// state  | meaning
// IDLE   | waiting for start; rule latched on accept
// LOAD_N | torus only: read row ROWS-1 into nbuf
// LOAD_C | read row 0 into cbuf (and tbuf in torus mode)
// LOAD_S | read row r+1 into sbuf
// WRITE  | write COLS new cells of row r
// SHIFT  | slide nbuf/cbuf/sbuf down one row, advance r
// DONE   | update_done pulse, back to IDLE
module automaton_grid_engine
   import automaton_pkg::*;
#(
   parameter int ROWS  = 64,
   parameter int COLS  = 64,
   parameter int ROW_W = $clog2(ROWS),
   parameter int COL_W = $clog2(COLS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [RULE_W-1:0] rule,
   output logic              busy,
   output logic [ROW_W-1:0]  row,
   output logic [COL_W-1:0]  col,
   output logic              world_we,
   input  logic              world_in,
   output logic              world_out,
   output logic              update_done
);

   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

   state_t            state;
   logic [RULE_W-1:0] rule_q;
   logic [ROW_W-1:0]  r_q;
   logic [COLS-1:0]   nbuf, cbuf, sbuf, edge_row;
   logic              accept, shift_on, last_next;
   logic              n_bit_we, n_par_we;
   logic [COLS-1:0]   n_par_val;
   logic              wrap_w, wrap_e, nb_w, nb_e;

   assign accept    = (state == IDLE) && start;
   assign shift_on  = (state == SHIFT);
   assign last_next = ((r_q + ROW_W'(1)) == ROW_LAST);

`ifdef AUTOMATON_TORUS_EN
   logic [COLS-1:0] tbuf;

   automaton_line_buf #(.COLS(COLS), .COL_W(COL_W)) u_tbuf (
      .clk(clk), .bit_we(state == LOAD_C), .bit_idx(col), .bit_val(world_in),
      .par_we(1'b0), .par_val('0), .q(tbuf)
   );

   assign n_bit_we  = (state == LOAD_N);
   assign n_par_we  = shift_on;
   assign n_par_val = cbuf;
   assign edge_row  = tbuf;
   assign wrap_w    = cbuf[COLS-1];
   assign wrap_e    = cbuf[0];
`else
   // Row -1 reads as zero: nbuf is cleared when a generation is accepted.
   assign n_bit_we  = 1'b0;
   assign n_par_we  = shift_on || accept;
   assign n_par_val = shift_on ? cbuf : '0;
   assign edge_row  = '0;
   assign wrap_w    = 1'b0;
   assign wrap_e    = 1'b0;
`endif

   automaton_line_buf #(.COLS(COLS), .COL_W(COL_W)) u_nbuf (
      .clk(clk), .bit_we(n_bit_we), .bit_idx(col), .bit_val(world_in),
      .par_we(n_par_we), .par_val(n_par_val), .q(nbuf)
   );

   automaton_line_buf #(.COLS(COLS), .COL_W(COL_W)) u_cbuf (
      .clk(clk), .bit_we(state == LOAD_C), .bit_idx(col), .bit_val(world_in),
      .par_we(shift_on), .par_val(sbuf), .q(cbuf)
   );

   // Entering the last row there is no LOAD_S pass; sbuf takes the edge row instead.
   automaton_line_buf #(.COLS(COLS), .COL_W(COL_W)) u_sbuf (
      .clk(clk), .bit_we(state == LOAD_S), .bit_idx(col), .bit_val(world_in),
      .par_we(shift_on && last_next), .par_val(edge_row), .q(sbuf)
   );

   always_comb begin
      nb_w      = (col == '0)       ? wrap_w : cbuf[col - COL_W'(1)];
      nb_e      = (col == COL_LAST) ? wrap_e : cbuf[col + COL_W'(1)];
      world_out = rule_q[rule_idx(nbuf[col], nb_w, cbuf[col], nb_e, sbuf[col])];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         update_done <= 1'b0;
         world_we    <= 1'b0;
         row         <= '0;
         col         <= '0;
         r_q         <= '0;
         rule_q      <= '0;
      end else begin
         update_done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  rule_q <= rule;
                  r_q    <= '0;
                  busy   <= 1'b1;
                  col    <= '0;
`ifdef AUTOMATON_TORUS_EN
                  row    <= ROW_LAST;
                  state  <= LOAD_N;
`else
                  row    <= '0;
                  state  <= LOAD_C;
`endif
               end
            end
`ifdef AUTOMATON_TORUS_EN
            LOAD_N: begin
               if (col == COL_LAST) begin
                  col   <= '0;
                  row   <= '0;
                  state <= LOAD_C;
               end else
                  col <= col + COL_W'(1);
            end
`endif
            LOAD_C: begin
               if (col == COL_LAST) begin
                  col   <= '0;
                  row   <= ROW_W'(1);
                  state <= LOAD_S;
               end else
                  col <= col + COL_W'(1);
            end
            LOAD_S: begin
               if (col == COL_LAST) begin
                  col      <= '0;
                  row      <= r_q;
                  world_we <= 1'b1;
                  state    <= WRITE;
               end else
                  col <= col + COL_W'(1);
            end
            WRITE: begin
               if (col == COL_LAST) begin
                  world_we <= 1'b0;
                  state    <= SHIFT;
               end else
                  col <= col + COL_W'(1);
            end
            SHIFT: begin
               if (r_q == ROW_LAST) begin
                  busy        <= 1'b0;
                  update_done <= 1'b1;
                  state       <= DONE;
               end else begin
                  r_q <= r_q + ROW_W'(1);
                  col <= '0;
                  if (last_next) begin
                     row      <= r_q + ROW_W'(1);
                     world_we <= 1'b1;
                     state    <= WRITE;
                  end else begin
                     row   <= r_q + ROW_W'(2);
                     state <= LOAD_S;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
